adc_sample_capture: RTL and testbench

Front-end capture stage of the IAGC datapath: registers raw 14-bit ADC words on the rising edge of the converter's data-ready line, converts offset-binary to two's complement, optionally block-averages, and buffers results in a small FIFO. Its valid/ready output feeds the sign extensor, which widens samples to the 16-bit gain-control datapath.

---
 rtl/adc_capture_pkg.sv | 13 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/adc_sample_capture.sv | 155 +++++++++++++++
 tb/tb_adc_sample_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture front end.
package adc_capture_pkg;

    localparam int ADC_DATA_SIZE   = 14;
    localparam int DROP_COUNT_SIZE = 16;

    typedef logic [ADC_DATA_SIZE-1:0] sample_t;

    function automatic sample_t offset_to_twos(input sample_t w);
        return {~w[ADC_DATA_SIZE-1], w[ADC_DATA_SIZE-2:0]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through FIFO; a push while full is accepted only alongside a pop.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Head is forced to zero while empty so storage needs no reset.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/adc_sample_capture.sv
// ADC capture front end: edge detect, offset-binary conversion, optional block
// averaging (compiled in by ADC_CAPTURE_AVG_EN), output FIFO and drop accounting.
module adc_sample_capture
    import adc_capture_pkg::*;
#(
    parameter int INPUT_DATA_SIZE = ADC_DATA_SIZE,
    parameter int FIFO_DEPTH      = 4,
    parameter int AVG_LOG2        = 2
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       enable,
    input  logic                       offsetBinary,
    input  logic [INPUT_DATA_SIZE-1:0] adcData,
    input  logic                       adcDataReady,
    output logic [INPUT_DATA_SIZE-1:0] outputData,
    output logic                       outputValid,
    input  logic                       outputReady,
    output logic                       overflow,
    input  logic                       clearOverflow,
    output logic [DROP_COUNT_SIZE-1:0] dropCount
);

    logic                       rdy_hist_q;
    logic                       capture;
    logic                       vld_p0_q;
    logic [INPUT_DATA_SIZE-1:0] data_p0_q;
    logic                       push_vld;
    logic [INPUT_DATA_SIZE-1:0] push_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       drop;
    logic                       overflow_q, overflow_d;
    logic [DROP_COUNT_SIZE-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [DROP_COUNT_SIZE-1:0] sat_inc(input logic [DROP_COUNT_SIZE-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign capture = enable & adcDataReady & ~rdy_hist_q;

    // Stage p0: capture and convert on the rising edge of data-ready.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdy_hist_q <= 1'b0;
            vld_p0_q   <= 1'b0;
        end else begin
            rdy_hist_q <= adcDataReady;
            vld_p0_q   <= capture;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            data_p0_q <= offsetBinary ? offset_to_twos(adcData) : adcData;
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    localparam int ACC_W = INPUT_DATA_SIZE + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0]        cnt_q;
    logic                       vld_p1_q;
    logic [INPUT_DATA_SIZE-1:0] data_p1_q;
    logic                       blk_done;

    function automatic logic [INPUT_DATA_SIZE-1:0] floor_avg(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] sh;
        sh = s >>> AVG_LOG2;
        return sh[INPUT_DATA_SIZE-1:0];
    endfunction

    assign acc_sum  = acc_q + ACC_W'(signed'(data_p0_q));
    assign blk_done = enable & vld_p0_q & (cnt_q == CNT_LAST);

    // Stage p1: accumulate; the block's final sample emits the floored mean.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= blk_done;
            if (!enable || blk_done) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (vld_p0_q) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (blk_done) begin
            data_p1_q <= floor_avg(acc_sum);
        end
    end

    assign push_vld  = vld_p1_q;
    assign push_data = data_p1_q;
`else
    assign push_vld  = vld_p0_q;
    assign push_data = data_p0_q;
`endif

    assign outputValid = ~fifo_empty;
    assign pop         = outputValid & outputReady;
    assign drop        = push_vld & fifo_full & ~pop;

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = clearOverflow ? DROP_COUNT_SIZE'(1) : sat_inc(drop_cnt_q);
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow  = overflow_q;
    assign dropCount = drop_cnt_q;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INPUT_DATA_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .push_i  (push_vld),
        .data_i  (push_data),
        .pop_i   (outputReady),
        .data_o  (outputData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_adc_sample_capture.sv
// Self-checking bench for adc_sample_capture; works with or without ADC_CAPTURE_AVG_EN.
module tb_adc_sample_capture;

`ifdef ADC_CAPTURE_AVG_EN
    localparam int AVGN = 4;
    localparam int LAT  = 2;
`else
    localparam int AVGN = 1;
    localparam int LAT  = 1;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        enable = 1'b0;
    logic        offsetBinary = 1'b0;
    logic [13:0] adcData = '0;
    logic        adcDataReady = 1'b0;
    logic        outputReady = 1'b0;
    logic        clearOverflow = 1'b0;
    logic [13:0] outputData;
    logic        outputValid;
    logic        overflow;
    logic [15:0] dropCount;

    int          tests_run = 0;
    int          fails = 0;
    logic [13:0] got[$];
    logic [13:0] exp_q[$];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    adc_sample_capture #(
        .INPUT_DATA_SIZE (14),
        .FIFO_DEPTH      (4),
        .AVG_LOG2        (2)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .enable        (enable),
        .offsetBinary  (offsetBinary),
        .adcData       (adcData),
        .adcDataReady  (adcDataReady),
        .outputData    (outputData),
        .outputValid   (outputValid),
        .outputReady   (outputReady),
        .overflow      (overflow),
        .clearOverflow (clearOverflow),
        .dropCount     (dropCount)
    );

    always @(negedge clk) begin
        if (mon_en && outputValid && outputReady) got.push_back(outputData);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Signed value of an ADC word after conversion.
    function automatic int sval(input logic [13:0] w, input logic ob);
        int v;
        v = ob ? int'(w ^ 14'h2000) : int'(w);
        if (v >= 8192) v = v - 16384;
        return v;
    endfunction

    // Floor of the block mean, as a 14-bit two's-complement word.
    function automatic logic [13:0] avg_exp(input int blk[$]);
        int s, q;
        logic [31:0] u;
        s = 0;
        foreach (blk[i]) s += blk[i];
        q = s / AVGN;
        if ((s % AVGN) != 0 && s < 0) q = q - 1;
        u = q;
        return u[13:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data-ready pulse; optionally clear/pop during the cycle the result is written.
    task automatic send_sample(input logic [13:0] w, input logic ob, input logic wr_clr, input logic wr_pop);
        adcData = w;
        offsetBinary = ob;
        adcDataReady = 1'b1;
        tick();
        adcDataReady = 1'b0;
        if (LAT == 2) tick();
        if (wr_clr) clearOverflow = 1'b1;
        if (wr_pop) outputReady = 1'b1;
        tick();
        clearOverflow = 1'b0;
        if (wr_pop) outputReady = 1'b0;
    endtask

    task automatic collect(input int n);
        outputReady = 1'b1;
        repeat (n) begin
            if (outputValid) got.push_back(outputData);
            tick();
        end
        outputReady = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstN = 1'b0;
        #2;
        tests_run++; if (outputValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", outputValid); end
        tests_run++; if (outputData !== 14'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", outputData); end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tests_run++; if (dropCount !== 16'h0) begin fails++; $display("FAIL reset_dropcount: got %h want 0000", dropCount); end
        repeat (3) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        tick();
    endtask

    task automatic test_offset();
        logic [13:0] w, e;
        enable = 1'b1;
        outputReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 14'h2000 : 14'h1FFF;
            e = (k == 0) ? 14'h0000 : 14'h3FFF;
            repeat (AVGN - 1) send_sample(w, 1'b1, 1'b0, 1'b0);
            adcData = w;
            offsetBinary = 1'b1;
            adcDataReady = 1'b1;
            tick();
            adcDataReady = 1'b0;
            tests_run++; if (outputValid !== 1'b0) begin fails++; $display("FAIL offset_early_valid[%0d]: got %b want 0", k, outputValid); end
            repeat (LAT - 1) tick();
            tick();
            tests_run++; if (outputValid !== 1'b1) begin fails++; $display("FAIL offset_valid[%0d]: got %b want 1", k, outputValid); end
            tests_run++; if (outputData !== e) begin fails++; $display("FAIL offset_data[%0d]: got %h want %h", k, outputData, e); end
            tick();
            tests_run++; if (outputValid !== 1'b0) begin fails++; $display("FAIL offset_popped[%0d]: got %b want 0", k, outputValid); end
        end
        outputReady = 1'b0;
    endtask

`ifdef ADC_CAPTURE_AVG_EN
    task automatic test_average();
        logic [13:0] a[4];
        logic [13:0] b[4];
        a[0] = 14'h0004; a[1] = 14'h0004; a[2] = 14'h0004; a[3] = 14'h3FFF;
        b[0] = 14'h3FFF; b[1] = 14'h3FFF; b[2] = 14'h3FFF; b[3] = 14'h3FFE;
        enable = 1'b1;
        outputReady = 1'b0;
        for (int i = 0; i < 4; i++) send_sample(a[i], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_sample(b[i], 1'b0, 1'b0, 1'b0);
        got.delete();
        collect(8);
        tests_run++; if (got.size() != 2) begin fails++; $display("FAIL avg_count: got %0d want 2", got.size()); end
        if (got.size() >= 2) begin
            tests_run++; if (got[0] !== 14'h0002) begin fails++; $display("FAIL avg_pos: got %h want 0002", got[0]); end
            tests_run++; if (got[1] !== 14'h3FFE) begin fails++; $display("FAIL avg_neg: got %h want 3ffe", got[1]); end
        end
    endtask
`endif

    task automatic test_overflow();
        logic [13:0] w;
        logic        ob;
        int          blk[$];
        enable = 1'b1;
        outputReady = 1'b0;
        exp_q.delete();
        for (int s = 0; s < 7; s++) begin
            blk.delete();
            for (int j = 0; j < AVGN; j++) begin
                w = 14'($urandom);
                ob = 1'($urandom);
                blk.push_back(sval(w, ob));
                send_sample(w, ob, (s == 6 && j == AVGN - 1), 1'b0);
            end
            if (s < 4) exp_q.push_back(avg_exp(blk));
            if (s == 5) begin
                tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
                tests_run++; if (dropCount !== 16'd2) begin fails++; $display("FAIL ovf_dropcount: got %0d want 2", dropCount); end
                tests_run++; if (outputData !== exp_q[0]) begin fails++; $display("FAIL ovf_head: got %h want %h", outputData, exp_q[0]); end
            end
        end
        tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_clr_drop_flag: got %b want 1", overflow); end
        tests_run++; if (dropCount !== 16'd1) begin fails++; $display("FAIL ovf_clr_drop_count: got %0d want 1", dropCount); end
        clearOverflow = 1'b1;
        tick();
        clearOverflow = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_cleared_flag: got %b want 0", overflow); end
        tests_run++; if (dropCount !== 16'd0) begin fails++; $display("FAIL ovf_cleared_count: got %0d want 0", dropCount); end
        got.delete();
        collect(10);
        tests_run++; if (got.size() != 4) begin fails++; $display("FAIL ovf_drain_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                tests_run++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic [13:0] w;
        logic        ob;
        int          blk[$];
        enable = 1'b1;
        outputReady = 1'b0;
        exp_q.delete();
        for (int s = 0; s < 5; s++) begin
            blk.delete();
            for (int j = 0; j < AVGN; j++) begin
                w = 14'($urandom);
                ob = 1'($urandom);
                blk.push_back(sval(w, ob));
                send_sample(w, ob, 1'b0, (s == 4 && j == AVGN - 1));
            end
            exp_q.push_back(avg_exp(blk));
        end
        void'(exp_q.pop_front());
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        tests_run++; if (dropCount !== 16'd0) begin fails++; $display("FAIL pp_dropcount: got %0d want 0", dropCount); end
        got.delete();
        collect(10);
        tests_run++; if (got.size() != 4) begin fails++; $display("FAIL pp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                tests_run++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL pp_order[%0d]: got %h want %h", i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_edge_enable();
        logic [13:0] w;
        int          blk[$];
        enable = 1'b1;
        outputReady = 1'b0;
        offsetBinary = 1'b0;
        w = 14'($urandom);
        adcData = w;
        blk.push_back(sval(w, 1'b0));
        adcDataReady = 1'b1;
        repeat (10) tick();
        adcDataReady = 1'b0;
        tick();
        for (int j = 0; j < AVGN - 1; j++) begin
            w = 14'($urandom);
            blk.push_back(sval(w, 1'b0));
            send_sample(w, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) tick();
        got.delete();
        collect(8);
        tests_run++; if (got.size() != 1) begin fails++; $display("FAIL held_ready_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            tests_run++; if (got[0] !== avg_exp(blk)) begin fails++; $display("FAIL held_ready_data: got %h want %h", got[0], avg_exp(blk)); end
        end
        enable = 1'b0;
        repeat (3) send_sample(14'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        tests_run++; if (outputValid !== 1'b0) begin fails++; $display("FAIL enable_off_valid: got %b want 0", outputValid); end
        enable = 1'b1;
        for (int j = 0; j < AVGN - 1; j++) send_sample(14'($urandom), 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        blk.delete();
        for (int j = 0; j < AVGN; j++) begin
            w = 14'($urandom);
            blk.push_back(sval(w, 1'b0));
            send_sample(w, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) tick();
        got.delete();
        collect(8);
        tests_run++; if (got.size() != 1) begin fails++; $display("FAIL discard_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            tests_run++; if (got[0] !== avg_exp(blk)) begin fails++; $display("FAIL discard_data: got %h want %h", got[0], avg_exp(blk)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] w;
        int          blk[$];
        enable = 1'b1;
        outputReady = 1'b0;
        for (int s = 0; s < 5 * AVGN + AVGN - 1; s++) send_sample(14'($urandom), 1'b0, 1'b0, 1'b0);
        tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL rmid_pre_overflow: got %b want 1", overflow); end
        #3 rstN = 1'b0;
        #1;
        tests_run++; if (outputValid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", outputValid); end
        tests_run++; if (outputData !== 14'h0) begin fails++; $display("FAIL rmid_data: got %h want 0000", outputData); end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
        tests_run++; if (dropCount !== 16'h0) begin fails++; $display("FAIL rmid_dropcount: got %h want 0000", dropCount); end
        @(negedge clk) rstN = 1'b1;
        tick();
        for (int j = 0; j < AVGN; j++) begin
            w = 14'($urandom);
            blk.push_back(sval(w, 1'b0));
            send_sample(w, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) tick();
        got.delete();
        collect(8);
        tests_run++; if (got.size() != 1) begin fails++; $display("FAIL rmid_post_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            tests_run++; if (got[0] !== avg_exp(blk)) begin fails++; $display("FAIL rmid_post_data: got %h want %h", got[0], avg_exp(blk)); end
        end
    endtask

    task automatic test_random_stream();
        logic [13:0] w;
        logic        ob;
        int          blk[$];
        enable = 1'b1;
        exp_q.delete();
        got.delete();
        mon_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            blk.delete();
            for (int j = 0; j < AVGN; j++) begin
                w = 14'($urandom);
                ob = 1'($urandom_range(0, 1));
                blk.push_back(sval(w, ob));
                outputReady = ($urandom_range(0, 3) != 0);
                send_sample(w, ob, 1'b0, 1'b0);
                repeat ($urandom_range(2, 4)) begin
                    outputReady = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            exp_q.push_back(avg_exp(blk));
        end
        outputReady = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;
        outputReady = 1'b0;
        tests_run++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                tests_run++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rand_data[%0d]: got %h want %h", i, got[i], exp_q[i]); end
            end
        end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_offset();
`ifdef ADC_CAPTURE_AVG_EN
        test_average();
`endif
        test_overflow();
        test_push_pop_full();
        test_edge_enable();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
